sl_axi_bridge_mp: RTL and testbench
===================================

Name: sl_axi_bridge_mp

Overview:
- Parametrised multi-port SRAM-like to AXI3 master bridge, one AXI transaction in flight.
- Sits between the icache/dcache (and any future uncached or DMA port) and the top-level AXI pins.
- Generalises the fixed two-port bridge in four ways:
  - N ports instead of two.
  - Read bursts of configurable length, for cache-line refill.
  - Per-port AXI ID.
  - Selectable arbitration.

Parameters:
- NUM_PORTS, 2, number of SRAM-like slave ports (1..8).
- MAX_LEN, 16, maximum read burst beats; sl_len is clamped to MAX_LEN-1.
- ID_W, 4, AXI ID width; ID = granted port index, zero-extended.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- sl_req  in  NUM_PORTS  per-port request.
- sl_wr  in  NUM_PORTS  1 = write.
- sl_size  in  2*NUM_PORTS  0 = byte, 1 = half, 2 = word.
- sl_len  in  8*NUM_PORTS  read beats minus 1; ignored for writes.
- sl_addr  in  32*NUM_PORTS  byte address.
- sl_wdata  in  32*NUM_PORTS  write data.
- sl_rdata  out  32  read beat data, shared by all ports.
- sl_rlast  out  1  final read beat.
- sl_addr_ok  out  NUM_PORTS  one-hot request accept.
- sl_data_ok  out  NUM_PORTS  one-hot beat / write-complete.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  ID_W/32/8/3/2/2/4/3/1  AXI AR channel.
- arready  in  1  AXI AR channel.
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  AXI R channel.
- rready  out  1  AXI R channel.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  same widths as AR  AXI AW channel.
- awready  in  1  AXI AW channel.
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1  AXI W channel.
- wready  in  1  AXI W channel.
- bid/bresp/bvalid  in  ID_W/2/1  AXI B channel.
- bready  out  1  AXI B channel.

Behaviour:
- Reset (aresetn low, asynchronous):
  - State is IDLE; arbitration pointer is 0.
  - All valid/ready outputs and all sl_addr_ok/sl_data_ok bits are 0.
  - Latched address, data, size, len and grant registers are 0.
  - A mid-transaction reset drops the transaction; the AXI slave is reset by the same aresetn.
- Constants:
  - arlock, awlock, arcache, awcache, arprot, awprot are all 0.
  - arburst = awburst = INCR (2'b01).
  - awlen = 0, wlast = 1, wid = awid.
- FSM states: IDLE, AR, R, AW_W, B.
- IDLE:
  - If any sl_req is set, the arbiter picks port g.
  - sl_addr_ok[g] = 1 combinationally in that cycle. Address, wdata, size and len of port g are latched on that edge.
  - Next state: AR if sl_wr[g] = 0, otherwise AW_W.
  - Non-granted ports see addr_ok = 0 and must hold their request.
- AR:
  - arvalid = 1; araddr, arid and arsize = {1'b0, size} come from the latches; arlen = min(len, MAX_LEN-1).
  - Outputs are stable until arready; on arvalid & arready go to R.
- R:
  - rready = 1.
  - On each rvalid: sl_rdata = rdata, sl_rlast = rlast and sl_data_ok[g] = 1, all combinational in the same cycle.
  - On rvalid & rlast go to IDLE.
  - rid is not checked; only one transaction is ever outstanding.
- AW_W:
  - awvalid and wvalid are raised together. Each drops independently after its own handshake, tracked by aw_done and w_done flags.
  - Go to B in the cycle both handshakes are complete, including when both happen in the same cycle.
  - wstrb:
    - size 0 gives 4'b0001 << addr[1:0].
    - size 1 gives 4'b0011 << {addr[1], 1'b0}.
    - size 2 or 3 gives 4'b1111; size 3 is treated as word.
- B: bready = 1; on bvalid, sl_data_ok[g] = 1 for one cycle, then IDLE.
- Throughput: at least one IDLE cycle between transactions. The bridge does not pipeline.
- rresp and bresp are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: SL_AXI_RR_ARB_EN.
- Defined:
  - Round-robin arbitration; priority starts at the port after the last grant, wrapping NUM_PORTS-1 to 0.
  - The pointer updates only on a grant.
- Undefined:
  - Fixed priority; the lowest index wins.
  - No pointer register is synthesised.

Decomposition:
- Package sl_axi_pkg holds:
  - The FSM state enum.
  - BURST_INCR, the AXI size encodings and the zero constants for lock/cache/prot.
  - The function for wstrb from size and address.
- One sub-module, sl_axi_arbiter: parametrised NUM_PORTS request vector in, one-hot grant plus index out.
  - Contains the SL_AXI_RR_ARB_EN logic.

Test Plan:
- Port 0 reads addr 0x1FC0_0000, len = 0; slave returns 0xDEAD_BEEF.
  - Expect arlen = 0 and arsize = 2.
  - Expect one sl_data_ok[0] with sl_rdata = 0xDEAD_BEEF and sl_rlast = 1.
- Port 1 reads with len = 7 and rvalid bubbles inserted.
  - Expect arlen = 7 and arid = 1.
  - Expect exactly 8 sl_data_ok[1] pulses with data in order, and sl_rlast only on beat 8.
- Port 0 byte write to 0x...03 with data 0x0000_00AA.
  - Expect wstrb = 4'b1000.
  - Vary awready/wready so they arrive in separate cycles and in the same cycle; expect one sl_data_ok[0], only after bvalid.
- Ports 0 and 1 request every cycle.
  - With SL_AXI_RR_ARB_EN: grants alternate 0, 1, 0, 1.
  - Without it: port 0 wins every time.
- Deassert aresetn during R state, mid-burst.
  - All outputs go to 0 immediately, the FSM returns to IDLE, and a new request is granted after reset is released.

Source files
------------

// File: rtl/sl_axi_pkg.sv
// sl_axi_pkg
//   Shared types and constants for the multi-port SRAM-like to AXI3 bridge:
//   the FSM state encoding, AXI burst/size/lock/cache/prot constants and the
//   write-strobe helper used on the W channel.
package sl_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] LOCK_ZERO  = 2'b00;
  localparam logic [3:0] CACHE_ZERO = 4'b0000;
  localparam logic [2:0] PROT_ZERO  = 3'b000;

  // Byte lanes touched by a single-beat write. Size 3 has no meaning on a
  // 32-bit bus and is folded into a full word.
  function automatic logic [3:0] wstrb_calc(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sl_axi_bridge_mp_arbiter.sv
// sl_axi_arbiter
//   Picks one of NUM_PORTS requesters. Default build is fixed priority
//   (lowest index wins, purely combinational). With SL_AXI_RR_ARB_EN defined
//   a rotating pointer gives first priority to the port after the last grant.
//
//   Ports:
//     aclk, aresetn  clock / async active-low reset (SL_AXI_RR_ARB_EN only)
//     accept         grant is being taken this cycle (SL_AXI_RR_ARB_EN only)
//     req            per-port request vector
//     grant          one-hot grant
//     grant_idx      index of the granted port
//     grant_vld      some port is granted
module sl_axi_arbiter
  import sl_axi_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
`ifdef SL_AXI_RR_ARB_EN
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 accept,
`endif
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_vld
);

`ifdef SL_AXI_RR_ARB_EN
  logic [IDX_W-1:0] ptr;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // Pointer holds the port with first priority next time; only moves on a grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr <= '0;
    end else if (accept && grant_vld) begin
      if (int'(grant_idx) == NUM_PORTS - 1) ptr <= '0;
      else                                  ptr <= grant_idx + IDX_W'(1);
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_vld && req[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
        grant[i]  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sl_axi_bridge_mp.sv
// sl_axi_bridge_mp
//   Multi-port SRAM-like slave to AXI3 master bridge, one transaction in
//   flight. Reads may be bursts (cache-line refill), writes are single beat.
//   AXI ID carries the granted port index. Arbitration is fixed priority
//   unless SL_AXI_RR_ARB_EN is defined, which selects round-robin.
//
//   Ports:
//     aclk, aresetn         clock, async active-low reset
//     sl_req/sl_wr          per-port request and direction (1 = write)
//     sl_size/sl_len        per-port size (0 b,1 h,2 w) and read beats-1
//     sl_addr/sl_wdata      per-port byte address and write data
//     sl_rdata/sl_rlast     read beat data and final-beat flag (shared)
//     sl_addr_ok            one-hot request accept
//     sl_data_ok            one-hot read beat / write complete
//     ar*/r*/aw*/w*/b*      AXI3 master channels
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for a request; arbiter grant accepted here
//   AR      | read address presented, waiting for arready
//   R       | forwarding read beats until rlast
//   AW_W    | write address and data presented, each drops on its handshake
//   B       | waiting for write response
module sl_axi_bridge_mp
  import sl_axi_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_LEN   = 16,
  parameter int ID_W      = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,

  input  logic [NUM_PORTS-1:0]   sl_req,
  input  logic [NUM_PORTS-1:0]   sl_wr,
  input  logic [2*NUM_PORTS-1:0] sl_size,
  input  logic [8*NUM_PORTS-1:0] sl_len,
  input  logic [32*NUM_PORTS-1:0] sl_addr,
  input  logic [32*NUM_PORTS-1:0] sl_wdata,
  output logic [31:0]            sl_rdata,
  output logic                   sl_rlast,
  output logic [NUM_PORTS-1:0]   sl_addr_ok,
  output logic [NUM_PORTS-1:0]   sl_data_ok,

  output logic [ID_W-1:0]        arid,
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,

  input  logic [ID_W-1:0]        rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,

  output logic [ID_W-1:0]        awid,
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,

  output logic [ID_W-1:0]        wid,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,

  input  logic [ID_W-1:0]        bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  localparam int         IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0] LEN_CAP = 8'(MAX_LEN - 1);

  state_e           state;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [1:0]       size_q;
  logic [7:0]       len_q;
  logic [IDX_W-1:0] gnt_q;
  logic             aw_done;
  logic             w_done;

  logic [NUM_PORTS-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_vld;
  logic                 idle;

  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic [7:0]  req_len;
  logic        req_wr;

  logic aw_hs;
  logic w_hs;

  // Only one transaction is ever outstanding, so IDs and responses carry no
  // information the bridge needs.
  logic unused_in;
  assign unused_in = ^{rid, rresp, bid, bresp};

  assign idle = (state == ST_IDLE);

  sl_axi_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
`ifdef SL_AXI_RR_ARB_EN
    .aclk      (aclk),
    .aresetn   (aresetn),
    .accept    (idle),
`endif
    .req       (sl_req),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  always_comb begin
    req_addr  = sl_addr [32*int'(arb_idx) +: 32];
    req_wdata = sl_wdata[32*int'(arb_idx) +: 32];
    req_size  = sl_size [2*int'(arb_idx)  +: 2];
    req_len   = sl_len  [8*int'(arb_idx)  +: 8];
    req_wr    = sl_wr   [arb_idx];
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            len_q   <= req_len;
            gnt_q   <= arb_idx;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= req_wr ? ST_AW_W : ST_AR;
          end
        end
        ST_AR: begin
          if (arready) state <= ST_R;
        end
        ST_R: begin
          if (rvalid && rlast) state <= ST_IDLE;
        end
        ST_AW_W: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // Either handshake may land first, or both together.
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_B;
        end
        ST_B: begin
          if (bvalid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Accept is combinational off the arbiter; gated by aresetn so a held
  // request is not acknowledged while the bridge sits in reset.
  assign sl_addr_ok = (idle && aresetn) ? arb_grant : '0;

  always_comb begin
    sl_data_ok = '0;
    if ((state == ST_R && rvalid) || (state == ST_B && bvalid))
      sl_data_ok[gnt_q] = 1'b1;
  end

  assign sl_rdata = (state == ST_R && rvalid) ? rdata : 32'h0;
  assign sl_rlast = (state == ST_R && rvalid) ? rlast : 1'b0;

  assign arid    = ID_W'(gnt_q);
  assign araddr  = addr_q;
  assign arlen   = (len_q > LEN_CAP) ? LEN_CAP : len_q;
  assign arsize  = {1'b0, size_q};
  assign arburst = BURST_INCR;
  assign arlock  = LOCK_ZERO;
  assign arcache = CACHE_ZERO;
  assign arprot  = PROT_ZERO;
  assign arvalid = (state == ST_AR);

  assign rready  = (state == ST_R);

  assign awid    = ID_W'(gnt_q);
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;
  assign awlock  = LOCK_ZERO;
  assign awcache = CACHE_ZERO;
  assign awprot  = PROT_ZERO;
  assign awvalid = (state == ST_AW_W) && !aw_done;

  assign wid     = awid;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_calc(size_q, addr_q[1:0]);
  assign wlast   = 1'b1;
  assign wvalid  = (state == ST_AW_W) && !w_done;

  assign bready  = (state == ST_B);

endmodule

// File: tb/tb_sl_axi_bridge_mp.sv
module tb_sl_axi_bridge_mp;

  localparam int NP   = 2;
  localparam int ID_W = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  logic [NP-1:0]    sl_req = '0;
  logic [NP-1:0]    sl_wr = '0;
  logic [2*NP-1:0]  sl_size = '0;
  logic [8*NP-1:0]  sl_len = '0;
  logic [32*NP-1:0] sl_addr = '0;
  logic [32*NP-1:0] sl_wdata = '0;
  logic [31:0]      sl_rdata;
  logic             sl_rlast;
  logic [NP-1:0]    sl_addr_ok;
  logic [NP-1:0]    sl_data_ok;

  logic [ID_W-1:0] arid;   logic [31:0] araddr; logic [7:0] arlen;
  logic [2:0] arsize;      logic [1:0] arburst; logic [1:0] arlock;
  logic [3:0] arcache;     logic [2:0] arprot;  logic arvalid;
  logic arready = 1'b0;
  logic [ID_W-1:0] rid = '0; logic [31:0] rdata = '0; logic [1:0] rresp = '0;
  logic rlast = 1'b0; logic rvalid = 1'b0; logic rready;
  logic [ID_W-1:0] awid;   logic [31:0] awaddr; logic [7:0] awlen;
  logic [2:0] awsize;      logic [1:0] awburst; logic [1:0] awlock;
  logic [3:0] awcache;     logic [2:0] awprot;  logic awvalid;
  logic awready = 1'b0;
  logic [ID_W-1:0] wid;    logic [31:0] wdata;  logic [3:0] wstrb;
  logic wlast; logic wvalid; logic wready = 1'b0;
  logic [ID_W-1:0] bid = '0; logic [1:0] bresp = '0; logic bvalid = 1'b0;
  logic bready;

  always #5 aclk = ~aclk;

  sl_axi_bridge_mp #(.NUM_PORTS(NP), .MAX_LEN(16), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .sl_req(sl_req), .sl_wr(sl_wr), .sl_size(sl_size), .sl_len(sl_len),
    .sl_addr(sl_addr), .sl_wdata(sl_wdata), .sl_rdata(sl_rdata),
    .sl_rlast(sl_rlast), .sl_addr_ok(sl_addr_ok), .sl_data_ok(sl_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int port; logic [31:0] addr; logic [7:0] len; logic [2:0] size; } ar_t;
  typedef struct { int port; logic [31:0] addr; logic [2:0] size; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { int port; logic rd; logic [31:0] data; logic last; } dok_t;

  ar_t  exp_ar[$];
  wr_t  exp_wr_aw[$];
  wr_t  exp_wr_w[$];
  dok_t exp_dok[$];
  int   exp_gnt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard monitor: samples on the falling edge, between drive and capture.
  always @(negedge aclk) begin
    ar_t  a;
    wr_t  w;
    dok_t d;
    int   g;
    if (aresetn) begin
      if (|sl_addr_ok) begin
        if (exp_gnt.size() == 0) check("addr_ok_unexpected", 32'(sl_addr_ok), 32'h0);
        else begin
          g = exp_gnt.pop_front();
          check("addr_ok_grant", 32'(sl_addr_ok), 32'(1) << g);
        end
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 32'(arvalid), 32'h0);
        else begin
          a = exp_ar.pop_front();
          check("araddr", araddr, a.addr);
          check("arlen", 32'(arlen), 32'(a.len));
          check("arsize", 32'(arsize), 32'(a.size));
          check("arid", 32'(arid), 32'(a.port));
          check("arburst", 32'(arburst), 32'h1);
        end
      end
      if (awvalid && awready) begin
        if (exp_wr_aw.size() == 0) check("aw_unexpected", 32'(awvalid), 32'h0);
        else begin
          w = exp_wr_aw.pop_front();
          check("awaddr", awaddr, w.addr);
          check("awsize", 32'(awsize), 32'(w.size));
          check("awid", 32'(awid), 32'(w.port));
          check("awlen", 32'(awlen), 32'h0);
        end
      end
      if (wvalid && wready) begin
        if (exp_wr_w.size() == 0) check("w_unexpected", 32'(wvalid), 32'h0);
        else begin
          w = exp_wr_w.pop_front();
          check("wdata", wdata, w.data);
          check("wstrb", 32'(wstrb), 32'(w.strb));
          check("wlast", 32'(wlast), 32'h1);
          check("wid", 32'(wid), 32'(w.port));
        end
      end
      if (|sl_data_ok) begin
        if (exp_dok.size() == 0) check("data_ok_unexpected", 32'(sl_data_ok), 32'h0);
        else begin
          d = exp_dok.pop_front();
          check("data_ok_port", 32'(sl_data_ok), 32'(1) << d.port);
          if (d.rd) begin
            check("sl_rdata", sl_rdata, d.data);
            check("sl_rlast", 32'(sl_rlast), 32'(d.last));
          end else begin
            check("wr_data_ok_with_bvalid", 32'(bvalid), 32'h1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_port(input int p, input logic wr, input logic [1:0] size,
                          input logic [7:0] len, input logic [31:0] addr,
                          input logic [31:0] wd);
    sl_wr[p]               = wr;
    sl_size[2*p +: 2]      = size;
    sl_len[8*p +: 8]       = len;
    sl_addr[32*p +: 32]    = addr;
    sl_wdata[32*p +: 32]   = wd;
  endtask

  // Returns at the cycle following the accepting edge.
  task automatic wait_addr_ok();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge aclk);
      seen = |sl_addr_ok;
    end
    if (!seen) timeout_fail("addr_ok_wait");
    tick();
  endtask

  task automatic issue(input int p, input logic wr, input logic [1:0] size,
                       input logic [7:0] len, input logic [31:0] addr,
                       input logic [31:0] wd);
    set_port(p, wr, size, len, addr, wd);
    sl_req[p] = 1'b1;
    wait_addr_ok();
    sl_req[p] = 1'b0;
  endtask

  task automatic push_read(input int p, input logic [31:0] addr, input logic [7:0] exp_len,
                           input logic [31:0] base, input int nbeats, input int last_idx);
    ar_t  a;
    dok_t d;
    exp_gnt.push_back(p);
    a.port = p; a.addr = addr; a.len = exp_len; a.size = 3'd2;
    exp_ar.push_back(a);
    for (int b = 0; b < nbeats; b++) begin
      d.port = p; d.rd = 1'b1; d.data = base + 32'(b); d.last = (b == last_idx);
      exp_dok.push_back(d);
    end
  endtask

  task automatic push_write(input int p, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] data, input logic [3:0] strb);
    wr_t  w;
    dok_t d;
    exp_gnt.push_back(p);
    w.port = p; w.addr = addr; w.size = {1'b0, size}; w.data = data; w.strb = strb;
    exp_wr_aw.push_back(w);
    exp_wr_w.push_back(w);
    d.port = p; d.rd = 1'b0; d.data = 32'h0; d.last = 1'b0;
    exp_dok.push_back(d);
  endtask

  task automatic slave_ar(input int dly);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (arvalid && i >= dly) begin
        arready = 1'b1;
        tick();
        arready = 1'b0;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    if (!done) timeout_fail("arvalid_wait");
  endtask

  task automatic slave_r(input int nbeats, input int last_idx, input logic [31:0] base,
                         input logic [15:0] bubbles);
    int k;
    for (int b = 0; b < nbeats; b++) begin
      if (bubbles[b]) tick();
      rvalid = 1'b1;
      rdata  = base + 32'(b);
      rlast  = (b == last_idx);
      k = 0;
      while (!rready && k < 50) begin tick(); k++; end
      if (!rready) timeout_fail("rready_wait");
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
  endtask

  task automatic slave_wr(input int aw_dly, input int w_dly, input int b_dly);
    int k;
    int last;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int c = 0; c <= last; c++) begin
      awready = (c == aw_dly);
      wready  = (c == w_dly);
      tick();
    end
    awready = 1'b0;
    wready  = 1'b0;
    for (int c = 0; c < b_dly; c++) tick();
    bvalid = 1'b1;
    k = 0;
    while (!bready && k < 50) begin tick(); k++; end
    if (!bready) timeout_fail("bready_wait");
    tick();
    bvalid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_arvalid"}, 32'(arvalid), 32'h0);
    check({tag, "_awvalid"}, 32'(awvalid), 32'h0);
    check({tag, "_wvalid"}, 32'(wvalid), 32'h0);
    check({tag, "_rready"}, 32'(rready), 32'h0);
    check({tag, "_bready"}, 32'(bready), 32'h0);
    check({tag, "_addr_ok"}, 32'(sl_addr_ok), 32'h0);
    check({tag, "_data_ok"}, 32'(sl_data_ok), 32'h0);
    check({tag, "_sl_rdata"}, sl_rdata, 32'h0);
    check({tag, "_sl_rlast"}, 32'(sl_rlast), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[4];
`ifdef SL_AXI_RR_ARB_EN
    e = '{0, 1, 0, 1};
`else
    e = '{0, 0, 0, 0};
`endif

    // Reset state, with requests held to show accept is suppressed.
    sl_req = 2'b11;
    #12;
    check_quiet("reset");
    sl_req = '0;
    tick();
    aresetn = 1'b1;
    tick();

    // Single-beat read, port 0.
    push_read(0, 32'h1FC0_0000, 8'd0, 32'hDEAD_BEEF, 1, 0);
    issue(0, 1'b0, 2'd2, 8'd0, 32'h1FC0_0000, 32'h0);
    slave_ar(0);
    slave_r(1, 0, 32'hDEAD_BEEF, 16'h0);
    tick();

    // 8-beat burst, port 1, arready delayed, rvalid bubbles.
    push_read(1, 32'h0000_1000, 8'd7, 32'h5500_0000, 8, 7);
    issue(1, 1'b0, 2'd2, 8'd7, 32'h0000_1000, 32'h0);
    slave_ar(2);
    slave_r(8, 7, 32'h5500_0000, 16'b0000_0000_0100_1010);
    tick();

    // Length above MAX_LEN-1 is clamped to 15 (16 beats).
    push_read(0, 32'h0000_2000, 8'd15, 32'h6600_0000, 16, 15);
    issue(0, 1'b0, 2'd2, 8'd40, 32'h0000_2000, 32'h0);
    slave_ar(0);
    slave_r(16, 15, 32'h6600_0000, 16'h0);
    tick();

    // Writes with various strobe shapes and handshake orderings.
    push_write(0, 32'h8000_0003, 2'd0, 32'h0000_00AA, 4'b1000);
    issue(0, 1'b1, 2'd0, 8'd0, 32'h8000_0003, 32'h0000_00AA);
    slave_wr(0, 2, 1);
    tick();

    push_write(1, 32'h8000_0006, 2'd1, 32'hBEEF_0000, 4'b1100);
    issue(1, 1'b1, 2'd1, 8'd0, 32'h8000_0006, 32'hBEEF_0000);
    slave_wr(1, 1, 0);
    tick();

    push_write(0, 32'h8000_0008, 2'd2, 32'h1234_5678, 4'b1111);
    issue(0, 1'b1, 2'd2, 8'd0, 32'h8000_0008, 32'h1234_5678);
    slave_wr(3, 0, 2);
    tick();

    push_write(1, 32'h8000_0011, 2'd3, 32'hCAFE_F00D, 4'b1111);
    issue(1, 1'b1, 2'd3, 8'd0, 32'h8000_0011, 32'hCAFE_F00D);
    slave_wr(0, 0, 0);
    tick();

    // Both ports requesting continuously.
    set_port(0, 1'b0, 2'd2, 8'd0, 32'h0000_0100, 32'h0);
    set_port(1, 1'b0, 2'd2, 8'd0, 32'h0000_0200, 32'h0);
    sl_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push_read(e[k], (e[k] == 0) ? 32'h0000_0100 : 32'h0000_0200, 8'd0,
                32'h0000_00A0 + 32'(k), 1, 0);
      wait_addr_ok();
      if (k == 3) sl_req = '0;
      slave_ar(0);
      slave_r(1, 0, 32'h0000_00A0 + 32'(k), 16'h0);
    end
    tick();

    // Reset in the middle of a 4-beat burst after two beats.
    push_read(1, 32'h0000_3000, 8'd3, 32'h7700_0000, 2, 3);
    issue(1, 1'b0, 2'd2, 8'd3, 32'h0000_3000, 32'h0);
    slave_ar(0);
    slave_r(2, 3, 32'h7700_0000, 16'h0);
    aresetn = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h7700_0002;
    #1;
    check_quiet("midreset");
    rvalid = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();

    push_read(1, 32'h0000_4000, 8'd0, 32'h8800_0000, 1, 0);
    issue(1, 1'b0, 2'd2, 8'd0, 32'h0000_4000, 32'h0);
    slave_ar(0);
    slave_r(1, 0, 32'h8800_0000, 16'h0);
    tick();
    tick();

    check("left_exp_gnt", 32'(exp_gnt.size()), 32'h0);
    check("left_exp_ar", 32'(exp_ar.size()), 32'h0);
    check("left_exp_aw", 32'(exp_wr_aw.size()), 32'h0);
    check("left_exp_w", 32'(exp_wr_w.size()), 32'h0);
    check("left_exp_data_ok", 32'(exp_dok.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
